nios2_oci_pib_rx: RTL and testbench

Receive-side capture block for the Nios II OCI off-chip trace port. It samples the 18-bit double-pumped trace bus (tr_clk and tr_data) and reassembles each high-half/low-half pair into the original 36-bit trace word. Reassembled words are buffered in a small FIFO and presented on a valid/ready stream. The block sits in the trace-capture path, on a probe or a loopback test harness, opposite the on-chip trace packer, and runs on the same clock as the packer's clkx2 domain.

---
 rtl/nios2_oci_pib_pkg.sv | 22 ++
 rtl/nios2_oci_pib_rx_fifo.sv | 60 ++++++
 rtl/nios2_oci_pib_rx.sv | 162 ++++++++++++++++
 tb/tb_nios2_oci_pib_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_pib_pkg.sv
// Shared definitions for the OCI off-chip trace port: word geometry,
// phase encoding of tr_clk and the receive FSM state set.
package nios2_oci_pib_pkg;

  localparam int TW_W   = 36;
  localparam int HALF_W = 18;

  // tr_clk value that marks the high half (tw[35:18]); the low half uses the inverse.
  localparam logic PH_HI = 1'b1;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    WAIT_HI = 2'd1,
    GOT_HI  = 2'd2
  } pib_rx_state_e;

  // An all-zero trace word is the packer's idle filler.
  function automatic logic is_idle_word(input logic [TW_W-1:0] w);
    return (w == '0);
  endfunction

endpackage

// File: rtl/nios2_oci_pib_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for reassembled trace words.
// Pointers wrap naturally; a separate occupancy counter tells full from empty.
// The read port is combinational from the head slot and forced to zero when empty.
module nios2_oci_pib_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     jrst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/nios2_oci_pib_rx.sv
// Receive side of the OCI trace port: registers the double-pumped 18-bit
// bus, pairs high/low halves back into 36-bit words, filters idle words,
// buffers them in a FWFT FIFO and keeps overflow / sync-error statistics.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | not aligned (reset or rx_en=0); lows ignored silently
// WAIT_HI | aligned, expecting a high half; a low is a sync error
// GOT_HI  | high half held, expecting the low; a second high is an error
module nios2_oci_pib_rx
  import nios2_oci_pib_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit DROP_IDLE  = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          jrst_n,
  input  logic                          rx_en,
  input  logic                          tr_clk,
  input  logic [HALF_W-1:0]             tr_data,
  output logic [TW_W-1:0]               tw_out,
  output logic                          tw_valid,
  input  logic                          tw_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              sync_err_cnt,
  output logic [CNT_W-1:0]              drop_cnt,
  input  logic                          clr_stat
);

  logic                rx_ph;
  logic [HALF_W-1:0]   rx_d;

  pib_rx_state_e       state, state_nxt;
  logic [HALF_W-1:0]   hi_q, hi_nxt;
  logic                sync_err_evt;
  logic                asm_evt;

  logic                wr_vld;
  logic [TW_W-1:0]     wr_word;

  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push;
  logic                idle_drop;
  logic                drop_evt;

  // Input capture stage; the FSM only ever looks at these registered copies.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      rx_ph <= 1'b0;
      rx_d  <= '0;
    end else begin
      rx_ph <= tr_clk;
      rx_d  <= tr_data;
    end
  end

  // FSM state and held high half.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      state <= HUNT;
      hi_q  <= '0;
    end else begin
      state <= state_nxt;
      hi_q  <= hi_nxt;
    end
  end

  // Phase tracking: pair halves, flag out-of-sequence phases.
  always_comb begin
    state_nxt    = state;
    hi_nxt       = hi_q;
    sync_err_evt = 1'b0;
    asm_evt      = 1'b0;
    if (!rx_en) begin
      state_nxt = HUNT;
    end else begin
      case (state)
        HUNT: begin
          if (rx_ph == PH_HI) begin
            hi_nxt    = rx_d;
            state_nxt = GOT_HI;
          end
        end
        WAIT_HI: begin
          if (rx_ph == PH_HI) begin
            hi_nxt    = rx_d;
            state_nxt = GOT_HI;
          end else begin
            sync_err_evt = 1'b1;
          end
        end
        GOT_HI: begin
          if (rx_ph == PH_HI) begin
            // Keep the newest high half; the older one has lost its partner.
            hi_nxt       = rx_d;
            sync_err_evt = 1'b1;
          end else begin
            asm_evt   = 1'b1;
            state_nxt = WAIT_HI;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Assembled-word stage feeding the FIFO write decision one cycle later.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      wr_vld  <= 1'b0;
      wr_word <= '0;
    end else begin
      wr_vld <= asm_evt;
      if (asm_evt) wr_word <= {hi_q, rx_d};
    end
  end

  assign pop       = tw_valid & tw_ready;
  assign idle_drop = DROP_IDLE & is_idle_word(wr_word);
  assign push      = wr_vld & ~idle_drop & (~fifo_full | pop);
  assign drop_evt  = wr_vld & ~idle_drop & fifo_full & ~pop;
  assign tw_valid  = ~fifo_empty;

  nios2_oci_pib_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TW_W)
  ) u_fifo (
    .clk    (clk),
    .jrst_n (jrst_n),
    .push   (push),
    .wdata  (wr_word),
    .pop    (pop),
    .rdata  (tw_out),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Sticky overflow and saturating counters; a clear beats a same-cycle event.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      overflow     <= 1'b0;
      sync_err_cnt <= '0;
      drop_cnt     <= '0;
    end else if (clr_stat) begin
      overflow     <= 1'b0;
      sync_err_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (drop_evt) overflow <= 1'b1;
      if (drop_evt && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
      if (sync_err_evt && (sync_err_cnt != '1))
        sync_err_cnt <= sync_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_nios2_oci_pib_rx.sv
// Directed bench for nios2_oci_pib_rx. Two instances share stimulus: one
// drops idle words, the other keeps them. Inputs change on the falling edge
// and outputs are sampled on the falling edge.
module tb_nios2_oci_pib_rx;

  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              jrst_n;
  logic              rx_en;
  logic              tr_clk;
  logic [17:0]       tr_data;
  logic              tw_ready;
  logic              clr_stat;

  logic [35:0]       tw_out,       raw_tw_out;
  logic              tw_valid,     raw_tw_valid;
  logic [LVL_W-1:0]  fifo_level,   raw_fifo_level;
  logic              overflow,     raw_overflow;
  logic [7:0]        sync_err_cnt, raw_sync_err_cnt;
  logic [7:0]        drop_cnt,     raw_drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nios2_oci_pib_rx #(.FIFO_DEPTH(DEPTH), .DROP_IDLE(1'b1), .CNT_W(8)) u_dut (
    .clk(clk), .jrst_n(jrst_n), .rx_en(rx_en), .tr_clk(tr_clk), .tr_data(tr_data),
    .tw_out(tw_out), .tw_valid(tw_valid), .tw_ready(tw_ready), .fifo_level(fifo_level),
    .overflow(overflow), .sync_err_cnt(sync_err_cnt), .drop_cnt(drop_cnt),
    .clr_stat(clr_stat)
  );

  nios2_oci_pib_rx #(.FIFO_DEPTH(DEPTH), .DROP_IDLE(1'b0), .CNT_W(8)) u_dut_raw (
    .clk(clk), .jrst_n(jrst_n), .rx_en(rx_en), .tr_clk(tr_clk), .tr_data(tr_data),
    .tw_out(raw_tw_out), .tw_valid(raw_tw_valid), .tw_ready(tw_ready),
    .fifo_level(raw_fifo_level), .overflow(raw_overflow),
    .sync_err_cnt(raw_sync_err_cnt), .drop_cnt(raw_drop_cnt), .clr_stat(clr_stat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic half(input logic ph, input logic [17:0] d);
    @(negedge clk);
    tr_clk  = ph;
    tr_data = d;
  endtask

  // One idle cycle with capture still enabled so the last low half is consumed,
  // then capture is disabled (HUNT ignores idle lows without counting errors).
  task automatic end_stream();
    half(1'b0, 18'h0);
    @(negedge clk);
    rx_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [35:0] exp_w [DEPTH+2];
  logic [35:0] new_w;

  initial begin
    jrst_n   = 1'b0;
    rx_en    = 1'b0;
    tr_clk   = 1'b0;
    tr_data  = '0;
    tw_ready = 1'b1;
    clr_stat = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tw_out",   tw_out,       36'h0);
    chk("rst_valid",    tw_valid,     1'b0);
    chk("rst_level",    fifo_level,   0);
    chk("rst_overflow", overflow,     1'b0);
    chk("rst_sync_err", sync_err_cnt, 0);
    chk("rst_drop",     drop_cnt,     0);
    jrst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Alternating stream, consumer always ready
    rx_en = 1'b1;
    half(1'b1, 18'h2AAAA);
    half(1'b0, 18'h15555);
    half(1'b1, 18'h00001);
    half(1'b0, 18'h3FFFF);
    half(1'b0, 18'h0);
    chk("alt_w1_valid", tw_valid, 1'b1);
    chk("alt_w1",       tw_out,   36'hAAAA95555);
    @(negedge clk);
    rx_en = 1'b0;
    @(negedge clk);
    chk("alt_w2_valid", tw_valid, 1'b1);
    chk("alt_w2",       tw_out,   36'h00007FFFF);
    chk("alt_sync_err", sync_err_cnt, 0);
    @(negedge clk);
    chk("alt_drained",  tw_valid, 1'b0);

    // Two highs in a row: second replaces first, one error
    rx_en = 1'b1;
    half(1'b1, 18'h11111);
    half(1'b1, 18'h22222);
    half(1'b0, 18'h33333);
    end_stream();
    @(negedge clk);
    chk("dblhi_word",     tw_out,       36'h8888B3333);
    chk("dblhi_valid",    tw_valid,     1'b1);
    chk("dblhi_sync_err", sync_err_cnt, 1);
    @(negedge clk);
    chk("dblhi_one_word", tw_valid, 1'b0);
    pulse_clr();
    chk("dblhi_clr", sync_err_cnt, 0);

    // All-zero pair: dropped by the filtering instance, kept by the raw one
    tw_ready = 1'b0;
    rx_en = 1'b1;
    half(1'b1, 18'h0);
    half(1'b0, 18'h0);
    end_stream();
    @(negedge clk);
    chk("idle_drop_level",  fifo_level,     0);
    chk("idle_drop_valid",  tw_valid,       1'b0);
    chk("idle_keep_level",  raw_fifo_level, 1);
    chk("idle_keep_valid",  raw_tw_valid,   1'b1);
    chk("idle_keep_word",   raw_tw_out,     36'h0);
    chk("idle_no_overflow", overflow,       1'b0);
    tw_ready = 1'b1;
    @(negedge clk);
    tw_ready = 1'b0;
    chk("idle_keep_drained", raw_fifo_level, 0);

    // Overflow: DEPTH+2 words with consumer stalled
    for (int i = 0; i < DEPTH + 2; i++)
      exp_w[i] = {18'h00010 + 18'(i), 18'h20000 + 18'(i)};
    rx_en = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      half(1'b1, exp_w[i][35:18]);
      half(1'b0, exp_w[i][17:0]);
    end
    end_stream();
    @(negedge clk);
    chk("ovf_level",    fifo_level,   DEPTH);
    chk("ovf_flag",     overflow,     1'b1);
    chk("ovf_drop_cnt", drop_cnt,     2);
    chk("ovf_head",     tw_out,       exp_w[0]);
    chk("ovf_sync_err", sync_err_cnt, 0);
    repeat (3) @(negedge clk);
    chk("ovf_head_stable", tw_out, exp_w[0]);
    pulse_clr();
    chk("clr_overflow", overflow,     1'b0);
    chk("clr_drop",     drop_cnt,     0);
    chk("clr_sync_err", sync_err_cnt, 0);
    chk("clr_level",    fifo_level,   DEPTH);

    // Full FIFO, pair completes in the same cycle as a pop
    new_w = {18'h3C3C3, 18'h0F0F0};
    rx_en = 1'b1;
    half(1'b1, new_w[35:18]);
    half(1'b0, new_w[17:0]);
    half(1'b0, 18'h0);
    @(negedge clk);
    rx_en = 1'b0;
    tw_ready = 1'b1;
    @(negedge clk);
    tw_ready = 1'b0;
    chk("fullpop_level",    fifo_level, DEPTH);
    chk("fullpop_drop_cnt", drop_cnt,   0);
    chk("fullpop_overflow", overflow,   1'b0);
    chk("fullpop_head",     tw_out,     exp_w[1]);
    tw_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", tw_out, (i < DEPTH - 1) ? exp_w[i+1] : new_w);
      @(negedge clk);
    end
    chk("drain_empty", tw_valid, 1'b0);

    // rx_en dropped mid-word, re-enabled with a low half first
    rx_en = 1'b1;
    half(1'b1, 18'h12345);
    half(1'b0, 18'h00555);
    @(negedge clk);
    rx_en   = 1'b0;
    tr_clk  = 1'b0;
    tr_data = 18'h0;
    @(negedge clk);
    rx_en   = 1'b1;
    tr_data = 18'h00777;
    half(1'b0, 18'h0);
    @(negedge clk);
    rx_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rxen_no_word",  tw_valid,     1'b0);
    chk("rxen_level",    fifo_level,   0);
    chk("rxen_sync_err", sync_err_cnt, 0);

    // Asynchronous reset with three words buffered and a nonzero counter
    tw_ready = 1'b0;
    rx_en = 1'b1;
    half(1'b1, 18'h00AAA);
    half(1'b1, 18'h00BBB);
    half(1'b0, 18'h00CCC);
    half(1'b1, 18'h00DDD);
    half(1'b0, 18'h00EEE);
    half(1'b1, 18'h00FFF);
    half(1'b0, 18'h00123);
    end_stream();
    @(negedge clk);
    chk("pre_rst_level",    fifo_level,   3);
    chk("pre_rst_sync_err", sync_err_cnt, 1);
    chk("pre_rst_head",     tw_out,       {18'h00BBB, 18'h00CCC});
    #2 jrst_n = 1'b0;
    #1;
    chk("arst_tw_out",   tw_out,       36'h0);
    chk("arst_valid",    tw_valid,     1'b0);
    chk("arst_level",    fifo_level,   0);
    chk("arst_overflow", overflow,     1'b0);
    chk("arst_sync_err", sync_err_cnt, 0);
    chk("arst_drop",     drop_cnt,     0);
    @(negedge clk);
    jrst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
